// File: rtl/capture_controller.sv
// ============================================================================
// Module      : capture_controller
// Description : Decimates 16 channel inputs into sample FIFO writes, with
//               optional 2x8-bit packing and overflow halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_controller #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 narrow,
    input  logic [15:0]          chan_in,
    input  logic                 fifo_full,
    output logic [15:0]          sample_data,
    output logic                 sample_data_avail,
    output logic                 running,
    output logic                 overflow_flag,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam logic [DIV_WIDTH-1:0] c_DIV_ONE = DIV_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [DIV_WIDTH-1:0]   r_div_lat;
    logic [DIV_WIDTH-1:0]   r_div_cnt;
    logic                   r_narrow;
    logic                   r_half;
    logic [7:0]             r_low_byte;
    logic [15:0]            r_sample_data;
    logic                   r_avail;
    logic                   r_running;
    logic                   r_overflow;
    logic [CNT_WIDTH-1:0]   r_word_count;

    logic                   w_tick;
    logic [15:0]            w_word;
    logic [CNT_WIDTH-1:0]   w_count_inc;

    assign w_tick      = (r_div_cnt == '0);
    assign w_word      = r_narrow ? {chan_in[7:0], r_low_byte} : chan_in;
    assign w_count_inc = (&r_word_count) ? r_word_count : r_word_count + c_CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_div_lat     <= '0;
            r_div_cnt     <= '0;
            r_narrow      <= 1'b0;
            r_half        <= 1'b0;
            r_low_byte    <= '0;
            r_sample_data <= '0;
            r_avail       <= 1'b0;
            r_running     <= 1'b0;
            r_overflow    <= 1'b0;
            r_word_count  <= '0;
        end else begin
            r_avail <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    // start beats a coincident stop; HALT keeps its flags on stop
                    if (start) begin
                        r_state      <= S_RUN;
                        r_running    <= 1'b1;
                        r_div_lat    <= divider;
                        r_narrow     <= narrow;
                        r_div_cnt    <= '0;
                        r_half       <= 1'b0;
                        r_overflow   <= 1'b0;
                        r_word_count <= '0;
                    end else if (stop) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_half    <= 1'b0;
                    end else begin
                        r_div_cnt <= w_tick ? r_div_lat : r_div_cnt - c_DIV_ONE;
                        if (w_tick) begin
                            if (r_narrow && !r_half) begin
                                r_low_byte <= chan_in[7:0];
                                r_half     <= 1'b1;
                            end else begin
                                r_half <= 1'b0;
                                if (fifo_full) begin
                                    r_overflow <= 1'b1;
                                    r_state    <= S_HALT;
                                    r_running  <= 1'b0;
                                end else begin
                                    r_sample_data <= w_word;
                                    r_avail       <= 1'b1;
                                    r_word_count  <= w_count_inc;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign sample_data       = r_sample_data;
    assign sample_data_avail = r_avail;
    assign running           = r_running;
    assign overflow_flag     = r_overflow;
    assign word_count        = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_capture_controller.sv
// Directed vector bench for capture_controller, plus a narrow-counter
// saturation sequence on a second instance.
`default_nettype none

module tb_capture_controller;

    logic        clk = 1'b0;
    logic        rst, start, stop, narrow, fifo_full;
    logic [15:0] divider;
    logic [15:0] chan_in;

    logic [15:0] sample_data;
    logic        sample_data_avail, running, overflow_flag;
    logic [31:0] word_count;

    logic [15:0] s_data;
    logic        s_avail, s_running, s_ovf;
    logic [3:0]  s_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    capture_controller #(.DIV_WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .divider(divider),
        .narrow(narrow), .chan_in(chan_in), .fifo_full(fifo_full),
        .sample_data(sample_data), .sample_data_avail(sample_data_avail),
        .running(running), .overflow_flag(overflow_flag), .word_count(word_count)
    );

    capture_controller #(.DIV_WIDTH(16), .CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .divider(divider),
        .narrow(narrow), .chan_in(chan_in), .fifo_full(fifo_full),
        .sample_data(s_data), .sample_data_avail(s_avail),
        .running(s_running), .overflow_flag(s_ovf), .word_count(s_count)
    );

    typedef struct {
        logic        rst, start, stop;
        logic [15:0] div;
        logic        nrw;
        logic [15:0] chan;
        logic        full;
        logic [15:0] e_data;
        logic        e_avail, e_run, e_ovf;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic sa, input logic so,
                       input logic [15:0] dv, input logic nw, input logic [15:0] ch,
                       input logic fl, input logic [15:0] ed, input logic ea,
                       input logic er, input logic eo, input logic [31:0] ec);
        vec_t v;
        v.rst = r; v.start = sa; v.stop = so; v.div = dv; v.nrw = nw;
        v.chan = ch; v.full = fl; v.e_data = ed; v.e_avail = ea;
        v.e_run = er; v.e_ovf = eo; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic sa, input logic so,
                         input logic [15:0] dv, input logic nw,
                         input logic [15:0] ch, input logic fl);
        rst = r; start = sa; stop = so; divider = dv; narrow = nw;
        chan_in = ch; fifo_full = fl;
    endtask

    initial begin
        drive(0, 0, 0, 16'd0, 0, 16'h0000, 0);

        // reset state
        add(1,0,0, 0,0, 16'h0000,0,  16'h0000,0,0,0, 0);
        // 16-bit, divider 0: eight back-to-back writes, stop on a tick
        add(0,1,0, 0,0, 16'h0000,0,  16'h0000,0,1,0, 0);
        for (int i = 0; i < 8; i++)
            add(0,0,0, 0,0, 16'(i),0, 16'(i),1,1,0, 32'(i+1));
        add(0,0,1, 0,0, 16'h0008,0,  16'h0007,0,0,0, 8);
        add(0,0,0, 0,0, 16'h0009,0,  16'h0007,0,0,0, 8);
        // 16-bit, divider 3; divider input changed mid-run has no effect
        add(0,1,0, 3,0, 16'h00FF,0,  16'h0007,0,1,0, 0);
        for (int j = 0; j < 9; j++) begin
            if (j % 4 == 0)
                add(0,0,0, 0,0, 16'(16'h0100+j),0, 16'(16'h0100+j),1,1,0, 32'(j/4+1));
            else
                add(0,0,0, 0,0, 16'(16'h0100+j),0, 16'(16'h0100+(j/4)*4),0,1,0, 32'(j/4+1));
        end
        add(0,0,1, 0,0, 16'h0109,0,  16'h0108,0,0,0, 3);
        // narrow, divider 1: pack pairs, partial byte dropped on stop
        add(0,1,0, 1,1, 16'h0000,0,  16'h0108,0,1,0, 0);
        add(0,0,0, 0,0, 16'hEE11,0,  16'h0108,0,1,0, 0);
        add(0,0,0, 0,0, 16'h00AA,0,  16'h0108,0,1,0, 0);
        add(0,0,0, 0,0, 16'hEE22,0,  16'h2211,1,1,0, 1);
        add(0,0,0, 0,0, 16'h00BB,0,  16'h2211,0,1,0, 1);
        add(0,0,0, 0,0, 16'hEE33,0,  16'h2211,0,1,0, 1);
        add(0,0,0, 0,0, 16'h00CC,0,  16'h2211,0,1,0, 1);
        add(0,0,0, 0,0, 16'hEE44,0,  16'h4433,1,1,0, 2);
        add(0,0,0, 0,0, 16'h00DD,0,  16'h4433,0,1,0, 2);
        add(0,0,0, 0,0, 16'hEE55,0,  16'h4433,0,1,0, 2);
        add(0,0,1, 0,0, 16'h0000,0,  16'h4433,0,0,0, 2);
        // restart narrow: the dropped 0x55 must not pair with the next byte
        add(0,1,0, 0,1, 16'h0000,0,  16'h4433,0,1,0, 0);
        add(0,0,0, 0,0, 16'h0066,0,  16'h4433,0,1,0, 0);
        add(0,0,0, 0,0, 16'h0077,0,  16'h7766,1,1,0, 1);
        add(0,0,1, 0,0, 16'h0000,0,  16'h7766,0,0,0, 1);
        // overflow halt, stop keeps flag, start clears it
        add(0,1,0, 0,0, 16'h0000,0,  16'h7766,0,1,0, 0);
        add(0,0,0, 0,0, 16'h0200,0,  16'h0200,1,1,0, 1);
        add(0,0,0, 0,0, 16'h0201,0,  16'h0201,1,1,0, 2);
        add(0,0,0, 0,0, 16'h0202,1,  16'h0201,0,0,1, 2);
        add(0,0,0, 0,0, 16'h0203,0,  16'h0201,0,0,1, 2);
        add(0,0,1, 0,0, 16'h0204,0,  16'h0201,0,0,1, 2);
        add(0,0,0, 0,0, 16'h0205,0,  16'h0201,0,0,1, 2);
        add(0,1,0, 0,0, 16'h0206,0,  16'h0201,0,1,0, 0);
        add(0,0,0, 0,0, 16'h0300,0,  16'h0300,1,1,0, 1);
        add(0,0,0, 0,0, 16'h0301,1,  16'h0300,0,0,1, 1);
        // start + stop together in HALT: start wins
        add(0,1,1, 0,0, 16'h0000,0,  16'h0300,0,1,0, 0);
        add(0,0,0, 0,0, 16'h0302,0,  16'h0302,1,1,0, 1);
        // reset with a write pending
        add(1,0,0, 0,0, 16'h0303,0,  16'h0000,0,0,0, 0);
        // start + stop together in IDLE: start wins
        add(0,1,1, 0,0, 16'h0000,0,  16'h0000,0,1,0, 0);
        add(0,0,0, 0,0, 16'h0400,0,  16'h0400,1,1,0, 1);
        add(0,0,1, 0,0, 16'h0401,0,  16'h0400,0,0,0, 1);

        @(negedge clk);
        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].start, vecs[k].stop, vecs[k].div,
                  vecs[k].nrw, vecs[k].chan, vecs[k].full);
            @(posedge clk);
            #1;
            checks++;
            if (sample_data !== vecs[k].e_data || sample_data_avail !== vecs[k].e_avail ||
                running !== vecs[k].e_run || overflow_flag !== vecs[k].e_ovf ||
                word_count !== vecs[k].e_cnt) begin
                errors++;
                $display("FAIL vec%0d: got data=%h avail=%b run=%b ovf=%b cnt=%0d, want data=%h avail=%b run=%b ovf=%b cnt=%0d",
                         k, sample_data, sample_data_avail, running, overflow_flag, word_count,
                         vecs[k].e_data, vecs[k].e_avail, vecs[k].e_run, vecs[k].e_ovf, vecs[k].e_cnt);
            end
            @(negedge clk);
        end

        // 4-bit counter saturation over 20 writes
        drive(1, 0, 0, 16'd0, 0, 16'h0000, 0);
        @(negedge clk);
        drive(0, 1, 0, 16'd0, 0, 16'h0000, 0);
        @(negedge clk);
        for (int n = 1; n <= 20; n++) begin
            drive(0, 0, 0, 16'd0, 0, 16'(n), 0);
            @(posedge clk);
            #1;
            checks++;
            if (s_count !== ((n > 15) ? 4'hF : 4'(n)) || s_avail !== 1'b1 || s_data !== 16'(n)) begin
                errors++;
                $display("FAIL sat_write%0d: got cnt=%h avail=%b data=%h, want cnt=%h avail=1 data=%h",
                         n, s_count, s_avail, s_data, ((n > 15) ? 4'hF : 4'(n)), 16'(n));
            end
            @(negedge clk);
        end
        drive(0, 0, 1, 16'd0, 0, 16'h0000, 0);
        @(negedge clk);
        drive(0, 0, 0, 16'd0, 0, 16'h0000, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/capture_controller.md
Name: capture_controller

Overview:
Sequences sample capture into the sample FIFO in the fast clock domain. Decimates the 16 input channels by a programmable divider and optionally packs two 8-channel samples per FIFO word. Drives the FIFO data and write-strobe inputs (currently tied off at top level). Detects FIFO overflow, halts capture on it and reports status to the configuration logic.

Parameters:
DIV_WIDTH, 16, width of the sample-rate divider (sample period = divider+1 clk cycles)
CNT_WIDTH, 32, width of the written-word counter

Ports:
clk  input  1  fast sample clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; begins a capture
stop  input  1  single-cycle pulse; ends capture / clears halt
divider  input  DIV_WIDTH  sample period minus one; latched at start
narrow  input  1  1 = 8-channel packed mode, 0 = 16-channel mode; latched at start
chan_in  input  16  channel inputs, already synchronised upstream
fifo_full  input  1  FIFO write-side full flag
sample_data  output  16  FIFO write data
sample_data_avail  output  1  FIFO write enable, one-cycle pulse per word
running  output  1  high in RUN state
overflow_flag  output  1  sticky; set when a word was dropped on full FIFO
word_count  output  CNT_WIDTH  words written since last start, saturating

Behaviour:
- Reset: state IDLE; sample_data=0, sample_data_avail=0, running=0, overflow_flag=0, word_count=0, divider counter=0, packing half-flag=0. Reset mid-capture aborts immediately; no further writes.
- States: IDLE, RUN, HALT.
- IDLE: start -> RUN next cycle. On that edge: latch divider/narrow, load divider counter with 0, clear half-flag, overflow_flag, word_count. stop in IDLE ignored.
- RUN: running=1. Tick when divider counter==0; counter then reloads latched divider, else decrements. First tick occurs on the first RUN cycle.
- Tick, 16-bit mode: word={chan_in}, emit.
- Tick, narrow mode: half-flag=0 -> store chan_in[7:0] as low byte, set half-flag, no emit. Half-flag=1 -> word={chan_in[7:0], stored low byte}, emit, clear half-flag.
- Emit: if fifo_full=0 on the tick cycle -> sample_data<=word, sample_data_avail=1 on the next cycle only, word_count+1 (saturates at all-ones). If fifo_full=1 -> no write, overflow_flag<=1, state -> HALT.
- Latency: chan_in sampled at tick edge; sample_data/avail valid the following cycle. Max write rate one per cycle (divider=0, 16-bit mode).
- sample_data holds its last value when avail=0.
- stop in RUN -> IDLE next cycle; tick in the same cycle is discarded; a pending narrow-mode low byte is discarded. stop has priority over start in RUN; start in RUN ignored.
- HALT: running=0, no writes, overflow_flag and word_count held. stop -> IDLE (flags retained). start -> RUN with the same clearing as from IDLE.
- Simultaneous start and stop in IDLE or HALT: start wins.
- divider/narrow changes while running have no effect until next start.

Test Plan:
- 16-bit, divider=0, chan_in increments each cycle from 0x0000, FIFO not full, start then stop after 8 cycles -> 8 avail pulses, one per cycle, data 0x0000..0x0007, word_count=8.
- 16-bit, divider=3 -> avail every 4th cycle, first one cycle after the first RUN cycle; data equals chan_in at the tick edges.
- Narrow, divider=1, chan_in[7:0] = 0x11, 0x22, 0x33, 0x44 on successive ticks -> words 0x2211, 0x4433; stop after a single further tick (0x55) -> no write of the partial byte.
- fifo_full raised before third emit -> two writes, overflow_flag=1, running=0, state HALT, no further avail; stop -> IDLE with overflow_flag still 1; start -> overflow_flag=0, word_count=0.
- rst asserted mid-RUN with avail pending -> next cycle avail=0, running=0, all outputs 0; start and stop in the same cycle from IDLE -> RUN.
- word_count preloaded near all-ones (CNT_WIDTH=4 build), 20 writes -> saturates at 0xF.
